// File: rtl/stopwatch_pkg.sv
// Shared stopwatch types and limits.
// Used by seconds control, minutes counter and display stages.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2
  } sw_state_e;

  localparam int SEC_W = 6;
  localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;
  localparam int MIN_W = 7;
  localparam logic [MIN_W-1:0] MIN_MAX = 7'd99;

endpackage

// File: rtl/sec_prescaler.sv
// Divides clk down to one tick per counted second.
// Holds its count while en is low; clr zeroes it.
module sec_prescaler #(
  parameter int TICKS_PER_SEC = 100000000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(TICKS_PER_SEC);
  localparam logic [CW-1:0] LAST = CW'(TICKS_PER_SEC - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/stopwatch_seconds_ctrl.sv
// Stopwatch run/pause FSM with seconds counter.
// Emits minute_en on 59->0 and count_clr on clear.
module stopwatch_seconds_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICKS_PER_SEC = 100000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  output logic             running,
  output logic [SEC_W-1:0] seconds,
  output logic             sec_tick,
  output logic             minute_en,
  output logic             count_clr
);

  sw_state_e        state;
  sw_state_e        state_n;
  logic             run_q;
  logic             clr_q;
  logic [SEC_W-1:0] sec_q;
  logic             tick;

  sec_prescaler #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_pre (
    .clk  (clk),
    .rst  (rst),
    .en   (state == RUNNING),
    .clr  (clear),
    .tick (tick)
  );

  always_comb begin
    state_n = state;
    priority case (1'b1)
      clear: state_n = IDLE;
      stop: begin
        if (state == RUNNING) state_n = PAUSED;
      end
      start: begin
        if (state != RUNNING) state_n = RUNNING;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      run_q <= 1'b0;
      clr_q <= 1'b0;
      sec_q <= '0;
    end else begin
      state <= state_n;
      run_q <= (state_n == RUNNING);
      clr_q <= clear;
      // clear wins over a coincident tick
      if (clear) begin
        sec_q <= '0;
      end else if (tick) begin
        sec_q <= (sec_q == SEC_MAX) ? '0 : sec_q + 1'b1;
      end
    end
  end

  assign running   = run_q;
  assign seconds   = sec_q;
  assign sec_tick  = tick;
  assign minute_en = tick && (sec_q == SEC_MAX);
  assign count_clr = clr_q;

endmodule

// File: tb/tb_stopwatch_seconds_ctrl.sv
// Directed bench for stopwatch_seconds_ctrl, TICKS_PER_SEC=4.
// Includes a small minutes counter driven by minute_en/count_clr.
module tb_stopwatch_seconds_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       clear = 1'b0;
  logic       running;
  logic [5:0] seconds;
  logic       sec_tick;
  logic       minute_en;
  logic       count_clr;
  logic [6:0] min_cnt;

  int checks = 0;
  int failures = 0;
  int nt;

  stopwatch_seconds_ctrl #(
    .TICKS_PER_SEC(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .clear     (clear),
    .running   (running),
    .seconds   (seconds),
    .sec_tick  (sec_tick),
    .minute_en (minute_en),
    .count_clr (count_clr)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) min_cnt <= '0;
    else if (count_clr) min_cnt <= '0;
    else if (minute_en) min_cnt <= min_cnt + 7'd1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, output int ticks);
    ticks = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (sec_tick) ticks++;
    end
  endtask

  initial begin
    // async reset before any clock edge
    #2 rst = 1'b1;
    #1;
    chk("rst_running", running, 0);
    chk("rst_seconds", seconds, 0);
    chk("rst_tick", sec_tick, 0);
    chk("rst_min_en", minute_en, 0);
    chk("rst_cclr", count_clr, 0);
    step();
    step();
    rst = 1'b0;
    run(6, nt);
    chk("idle_no_tick", nt, 0);
    chk("idle_running", running, 0);

    // start: running next cycle, tick on 4th running cycle
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_running", running, 1);
    chk("start_tick0", sec_tick, 0);
    step();
    chk("start_tick1", sec_tick, 0);
    step();
    chk("start_tick2", sec_tick, 0);
    step();
    chk("first_tick", sec_tick, 1);
    chk("first_tick_sec", seconds, 0);
    step();
    chk("sec_1", seconds, 1);
    chk("sec_1_tick", sec_tick, 0);

    // run up to 59 then wrap
    run(232, nt);
    chk("sec_59", seconds, 59);
    chk("ticks_to_59", nt, 58);
    run(3, nt);
    chk("wrap_tick", sec_tick, 1);
    chk("wrap_min_en", minute_en, 1);
    step();
    chk("wrap_sec", seconds, 0);
    chk("wrap_min_en_off", minute_en, 0);
    chk("min_cnt_1", min_cnt, 1);

    // pause at 10 with prescaler at 1, resume
    run(40, nt);
    chk("sec_10", seconds, 10);
    step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("pause_running", running, 0);
    run(20, nt);
    chk("pause_no_tick", nt, 0);
    chk("pause_sec", seconds, 10);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("resume_running", running, 1);
    chk("resume_tick0", sec_tick, 0);
    step();
    chk("resume_tick1", sec_tick, 1);
    step();
    chk("sec_11", seconds, 11);

    // start+stop+clear together while running
    run(2, nt);
    start = 1'b1;
    stop = 1'b1;
    clear = 1'b1;
    step();
    start = 1'b0;
    stop = 1'b0;
    clear = 1'b0;
    chk("clr_running", running, 0);
    chk("clr_sec", seconds, 0);
    chk("clr_pulse", count_clr, 1);
    step();
    chk("clr_pulse_end", count_clr, 0);
    chk("clr_min_cnt", min_cnt, 0);
    run(8, nt);
    chk("clr_idle_ticks", nt, 0);
    chk("clr_idle_sec", seconds, 0);

    // stop coincident with the 59->0 tick
    start = 1'b1;
    step();
    start = 1'b0;
    run(236, nt);
    chk("b_sec_59", seconds, 59);
    run(3, nt);
    chk("b_tick", sec_tick, 1);
    chk("b_min_en", minute_en, 1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("b_sec_wrap", seconds, 0);
    chk("b_running", running, 0);
    chk("b_min_cnt", min_cnt, 1);
    run(12, nt);
    chk("b_no_tick", nt, 0);
    chk("b_sec_hold", seconds, 0);

    // async reset mid-count at 30, during a tick cycle
    clear = 1'b1;
    step();
    clear = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    run(120, nt);
    chk("r_sec_30", seconds, 30);
    run(3, nt);
    chk("r_tick_pre", sec_tick, 1);
    #2 rst = 1'b1;
    #1;
    chk("r_running", running, 0);
    chk("r_seconds", seconds, 0);
    chk("r_tick", sec_tick, 0);
    chk("r_min_en", minute_en, 0);
    chk("r_cclr", count_clr, 0);
    step();
    #2 rst = 1'b0;
    run(10, nt);
    chk("r_no_tick", nt, 0);
    chk("r_idle_run", running, 0);

    // clear accepted in IDLE still pulses count_clr
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("idle_clr_pulse", count_clr, 1);
    step();
    chk("idle_clr_end", count_clr, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
